// File: rtl/lsu_pkg.sv
// Shared definitions for the AXI4-Lite load/store unit.
//   - access size encodings carried on ls_size
//   - AXI response codes and protection constants
//   - FSM state encodings shared by the top level
//   - misaligned(): alignment check for a given size and low address bits
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_FETCH = 3'b100;
   localparam logic [2:0] PROT_DATA  = 3'b000;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_RD_A   = 4'd1;
   localparam state_t ST_RD_D   = 4'd2;
   localparam state_t ST_WR_AWW = 4'd3;
   localparam state_t ST_WR_W   = 4'd4;
   localparam state_t ST_WR_AW  = 4'd5;
   localparam state_t ST_WR_B   = 4'd6;
   localparam state_t ST_RESP   = 4'd7;
   localparam state_t ST_ERR    = 4'd8;

   // A doubleword is only legal on a 64-bit bus; on a 32-bit bus it traps.
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [2:0] low,
                                       input logic       dword_ok);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = low[0];
         SZ_WORD: misaligned = |low[1:0];
         default: misaligned = !dword_ok || (|low);
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
//   size/is_signed/offset : latched access attributes (offset = low address bits)
//   st_data -> wdata/wstrb : store datum replicated across lanes, strobe at offset
//   rdata   -> ld_data     : lane extracted at offset, sign/zero extended
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [1:0]          size,
   input  logic                is_signed,
   input  logic [OFF_W-1:0]    offset,
   input  logic [DATA_W-1:0]   st_data,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic [DATA_W-1:0]   rdata,
   output logic [DATA_W-1:0]   ld_data
);

   localparam int NB = DATA_W / 8;

   logic [NB-1:0]     size_mask;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] keep;
   logic              ext_bit;

   // Each byte lane takes the datum byte that lands on it when the sized
   // datum is tiled across the bus; a DWORD on a 32-bit bus degenerates to WORD.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign wdata[gi*8 +: 8] = (size == SZ_BYTE) ? st_data[7:0] :
                                   (size == SZ_HALF) ? st_data[(gi % 2)*8 +: 8] :
                                   (size == SZ_WORD) ? st_data[(gi % 4)*8 +: 8] :
                                                       st_data[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      size_mask = NB'((1 << (1 << size)) - 1);
      wstrb     = size_mask << offset;
   end

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      keep    = '1;
      ext_bit = 1'b0;
      case (size)
         SZ_BYTE: begin
            keep    = DATA_W'(8'hFF);
            ext_bit = is_signed & shifted[7];
         end
         SZ_HALF: begin
            keep    = DATA_W'(16'hFFFF);
            ext_bit = is_signed & shifted[15];
         end
         SZ_WORD: begin
            keep    = DATA_W'(32'hFFFF_FFFF);
            ext_bit = is_signed & shifted[31];
         end
         default: begin
            keep    = '1;
            ext_bit = 1'b0;
         end
      endcase
      ld_data = (shifted & keep) | ({DATA_W{ext_bit}} & ~keep);
   end

endmodule

// File: rtl/axil_lsu_arb.sv
// AXI4-Lite load/store unit with fetch/load-store arbitration.
//   if_*  : instruction fetch requester (valid/ready request, response pulse)
//   ls_*  : load/store requester (valid/ready request, response pulse)
//   m_*   : single AXI4-Lite master; all outputs derive from registers only
// One transaction is in flight at a time; requests are accepted only in IDLE.
module axil_lsu_arb
   import lsu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int LS_PRIO = 1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_rsp_valid,
   output logic [31:0]         if_rsp_data,
   output logic                if_rsp_err,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic                ls_we,
   input  logic [1:0]          ls_size,
   input  logic                ls_signed,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rsp_rdata,
   output logic                ls_rsp_err,
   output logic                ls_misalign,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [2:0]          m_awprot,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [2:0]          m_arprot,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   state_t            state_reg, state_next;
   logic              is_fetch_reg, we_reg, signed_reg, err_reg, misalign_reg;
   logic [1:0]        size_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg, rsp_data_reg;

   logic              take_ls, take_if, accept, req_misalign, rsp_phase;
   logic [DATA_W-1:0] lane_wdata, ld_data;
   logic [NB-1:0]     lane_wstrb;
   logic [31:0]       fetch_word;

   // Fixed-priority grant; the loser simply keeps its valid asserted.
   always_comb begin
      if (LS_PRIO != 0) begin
         take_ls = ls_req_valid;
         take_if = if_req_valid & ~ls_req_valid;
      end else begin
         take_if = if_req_valid;
         take_ls = ls_req_valid & ~if_req_valid;
      end
   end

   assign accept       = (state_reg == ST_IDLE) && (take_ls || take_if);
   assign ls_req_ready = resetn && (state_reg == ST_IDLE) && take_ls;
   assign if_req_ready = resetn && (state_reg == ST_IDLE) && take_if;
   assign req_misalign = take_ls ? misaligned(ls_size, ls_addr[2:0], DATA_W == 64)
                                 : (|if_addr[1:0]);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:
            if (accept)
               state_next = req_misalign ? ST_ERR
                          : (take_ls && ls_we) ? ST_WR_AWW : ST_RD_A;
         ST_RD_A:
            if (m_arready) state_next = m_rvalid ? ST_RESP : ST_RD_D;
         ST_RD_D:
            if (m_rvalid) state_next = ST_RESP;
         ST_WR_AWW:
            case ({m_awready, m_wready})
               2'b11:   state_next = m_bvalid ? ST_RESP : ST_WR_B;
               2'b10:   state_next = ST_WR_W;
               2'b01:   state_next = ST_WR_AW;
               default: state_next = ST_WR_AWW;
            endcase
         ST_WR_W:
            if (m_wready) state_next = m_bvalid ? ST_RESP : ST_WR_B;
         ST_WR_AW:
            if (m_awready) state_next = m_bvalid ? ST_RESP : ST_WR_B;
         ST_WR_B:
            if (m_bvalid) state_next = ST_RESP;
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_reg    <= ST_IDLE;
         is_fetch_reg <= 1'b0;
         we_reg       <= 1'b0;
         signed_reg   <= 1'b0;
         size_reg     <= SZ_BYTE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rsp_data_reg <= '0;
         err_reg      <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            is_fetch_reg <= take_if;
            we_reg       <= take_ls & ls_we;
            signed_reg   <= take_ls & ls_signed;
            size_reg     <= take_ls ? ls_size : SZ_WORD;
            addr_reg     <= take_ls ? ls_addr : if_addr;
            wdata_reg    <= take_ls ? ls_wdata : '0;
            rsp_data_reg <= '0;
            err_reg      <= req_misalign;
            misalign_reg <= req_misalign;
         end else if (state_next == ST_RESP) begin
            misalign_reg <= 1'b0;
            if (we_reg) begin
               rsp_data_reg <= '0;
               err_reg      <= (m_bresp != RESP_OKAY);
            end else begin
               rsp_data_reg <= is_fetch_reg ? DATA_W'(fetch_word) : ld_data;
               err_reg      <= (m_rresp != RESP_OKAY);
            end
         end
      end
   end

   lsu_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
      .size      (size_reg),
      .is_signed (signed_reg),
      .offset    (addr_reg[OFF_W-1:0]),
      .st_data   (wdata_reg),
      .wdata     (lane_wdata),
      .wstrb     (lane_wstrb),
      .rdata     (m_rdata),
      .ld_data   (ld_data)
   );

   generate
      if (DATA_W == 64) begin : g_fetch64
         assign fetch_word = addr_reg[2] ? m_rdata[DATA_W-1:32] : m_rdata[31:0];
      end else begin : g_fetch32
         assign fetch_word = m_rdata[31:0];
      end
   endgenerate

   assign m_arvalid = (state_reg == ST_RD_A);
   assign m_rready  = (state_reg == ST_RD_A) || (state_reg == ST_RD_D);
   assign m_awvalid = (state_reg == ST_WR_AWW) || (state_reg == ST_WR_AW);
   assign m_wvalid  = (state_reg == ST_WR_AWW) || (state_reg == ST_WR_W);
   assign m_bready  = (state_reg == ST_WR_AWW) || (state_reg == ST_WR_W) ||
                      (state_reg == ST_WR_AW)  || (state_reg == ST_WR_B);
   assign m_araddr  = addr_reg;
   assign m_awaddr  = addr_reg;
   assign m_arprot  = is_fetch_reg ? PROT_FETCH : PROT_DATA;
   assign m_awprot  = PROT_DATA;
   assign m_wdata   = lane_wdata;
   // Strobes are only meaningful with wvalid; keep them quiet otherwise.
   assign m_wstrb   = m_wvalid ? lane_wstrb : '0;

   assign rsp_phase    = (state_reg == ST_RESP) || (state_reg == ST_ERR);
   assign if_rsp_valid = rsp_phase && is_fetch_reg;
   assign ls_rsp_valid = rsp_phase && !is_fetch_reg;
   assign if_rsp_data  = rsp_data_reg[31:0];
   assign ls_rsp_rdata = rsp_data_reg;
   assign if_rsp_err   = if_rsp_valid && err_reg;
   assign ls_rsp_err   = ls_rsp_valid && err_reg;
   assign ls_misalign  = ls_rsp_valid && misalign_reg;

endmodule

// File: tb/tb_axil_lsu_arb.sv
// Directed bench for axil_lsu_arb (DATA_W=32, LS_PRIO=1). Inputs change and
// outputs are checked just after the falling edge; the AXI slave is played
// inline by the stimulus sequence.
module tb_axil_lsu_arb;

   logic        clock = 1'b0;
   logic        resetn;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
   logic [31:0] if_addr, if_rsp_data;
   logic        ls_req_valid, ls_req_ready, ls_we, ls_signed;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata, ls_rsp_rdata;
   logic        ls_rsp_valid, ls_rsp_err, ls_misalign;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;

   int vectors = 0;
   int miscompares = 0;
   int arvalid_seen = 0;
   int ls_rsp_seen = 0;
   int a0, r0;

   axil_lsu_arb #(.DATA_W(32), .ADDR_W(32), .LS_PRIO(1)) dut (
      .clock(clock), .resetn(resetn),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
      .ls_size(ls_size), .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata), .ls_rsp_err(ls_rsp_err),
      .ls_misalign(ls_misalign),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (m_arvalid) arvalid_seen++;
      if (ls_rsp_valid) ls_rsp_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish (observed timeout, required completion)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends just after a falling edge with the DUT idle.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] rd, input logic [31:0] exp);
      ls_req_valid = 1'b1; ls_we = 1'b0; ls_size = size; ls_signed = sgn; ls_addr = addr;
      #1;
      chk({tag, " ls_req_ready"}, ls_req_ready, 1);
      @(negedge clock);
      ls_req_valid = 1'b0;
      chk({tag, " arvalid"}, m_arvalid, 1);
      chk({tag, " araddr"}, m_araddr, addr);
      chk({tag, " arprot"}, m_arprot, 3'b000);
      chk({tag, " no early rsp"}, ls_rsp_valid, 0);
      m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = rd; m_rresp = 2'b00;
      @(negedge clock);
      m_arready = 1'b0; m_rvalid = 1'b0;
      chk({tag, " rsp_valid"}, ls_rsp_valid, 1);
      chk({tag, " rdata"}, ls_rsp_rdata, exp);
      chk({tag, " err"}, ls_rsp_err, 0);
      @(negedge clock);
      chk({tag, " rsp single"}, ls_rsp_valid, 0);
      $display("load %s addr=0x%08h size=%0d signed=%0d rdata=0x%08h", tag, addr, size, sgn, exp);
   endtask

   initial begin
      resetn = 1'b0;
      if_req_valid = 0; if_addr = 0;
      ls_req_valid = 0; ls_we = 0; ls_size = 0; ls_signed = 0; ls_addr = 0; ls_wdata = 0;
      m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
      m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
      repeat (3) @(negedge clock);
      chk("reset arvalid", m_arvalid, 0);
      chk("reset awvalid", m_awvalid, 0);
      chk("reset wvalid", m_wvalid, 0);
      chk("reset wstrb", m_wstrb, 0);
      chk("reset araddr", m_araddr, 0);
      chk("reset ls_rsp_valid", ls_rsp_valid, 0);
      chk("reset if_rsp_valid", if_rsp_valid, 0);
      $display("reset state checked");
      resetn = 1'b1;

      // 1: word load, zero-wait slave
      do_load("t1 lw", 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
      // 2: byte loads from lane 3, signed then unsigned
      do_load("t2 lb", 32'h103, 2'b00, 1'b1, 32'h80000000, 32'hFFFFFF80);
      do_load("t2 lbu", 32'h103, 2'b00, 1'b0, 32'h80000000, 32'h00000080);
      do_load("t2 lh", 32'h102, 2'b01, 1'b1, 32'h9ABC0000, 32'hFFFF9ABC);

      // 3: halfword store, awready delayed, wready immediate
      ls_req_valid = 1; ls_we = 1; ls_size = 2'b01; ls_signed = 0; ls_addr = 32'h102; ls_wdata = 32'h1234;
      #1;
      chk("t3 ls_req_ready", ls_req_ready, 1);
      @(negedge clock);
      ls_req_valid = 0; ls_we = 0;
      chk("t3 awvalid", m_awvalid, 1);
      chk("t3 wvalid", m_wvalid, 1);
      chk("t3 wstrb", m_wstrb, 4'b1100);
      chk("t3 wdata", m_wdata, 32'h12341234);
      chk("t3 awaddr", m_awaddr, 32'h102);
      chk("t3 awprot", m_awprot, 3'b000);
      m_wready = 1; m_awready = 0;
      @(negedge clock);
      m_wready = 0;
      for (int k = 0; k < 2; k++) begin
         chk("t3 awvalid held", m_awvalid, 1);
         chk("t3 wvalid dropped", m_wvalid, 0);
         chk("t3 awaddr stable", m_awaddr, 32'h102);
         @(negedge clock);
      end
      chk("t3 awvalid held", m_awvalid, 1);
      m_awready = 1;
      @(negedge clock);
      m_awready = 0;
      chk("t3 awvalid done", m_awvalid, 0);
      chk("t3 bready", m_bready, 1);
      chk("t3 no rsp before b", ls_rsp_valid, 0);
      m_bvalid = 1; m_bresp = 2'b00;
      @(negedge clock);
      m_bvalid = 0;
      chk("t3 rsp_valid", ls_rsp_valid, 1);
      chk("t3 err", ls_rsp_err, 0);
      chk("t3 rdata zero", ls_rsp_rdata, 0);
      @(negedge clock);
      chk("t3 rsp single", ls_rsp_valid, 0);
      $display("store t3 sh addr=0x102 wdata=0x1234 done");

      // 4: misaligned word load traps without bus traffic
      a0 = arvalid_seen;
      ls_req_valid = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h101;
      #1;
      chk("t4 ls_req_ready", ls_req_ready, 1);
      @(negedge clock);
      ls_req_valid = 0;
      chk("t4 rsp_valid", ls_rsp_valid, 1);
      chk("t4 err", ls_rsp_err, 1);
      chk("t4 misalign", ls_misalign, 1);
      chk("t4 arvalid", m_arvalid, 0);
      @(negedge clock);
      chk("t4 rsp single", ls_rsp_valid, 0);
      chk("t4 no ar activity", arvalid_seen, a0);
      $display("misaligned t4 lw addr=0x101 trapped");

      // 5: simultaneous fetch and load; load first, then fetch with SLVERR
      if_req_valid = 1; if_addr = 32'h200;
      ls_req_valid = 1; ls_we = 0; ls_size = 2'b10; ls_signed = 0; ls_addr = 32'h104;
      #1;
      chk("t5 ls wins", ls_req_ready, 1);
      chk("t5 if waits", if_req_ready, 0);
      @(negedge clock);
      ls_req_valid = 0;
      chk("t5 ld araddr", m_araddr, 32'h104);
      chk("t5 ld arprot", m_arprot, 3'b000);
      chk("t5 if busy", if_req_ready, 0);
      m_arready = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00;
      @(negedge clock);
      m_arready = 0; m_rvalid = 0;
      chk("t5 ld rsp", ls_rsp_valid, 1);
      chk("t5 ld rdata", ls_rsp_rdata, 32'hCAFEF00D);
      chk("t5 no if rsp", if_rsp_valid, 0);
      chk("t5 if busy rsp", if_req_ready, 0);
      @(negedge clock);
      chk("t5 if granted", if_req_ready, 1);
      @(negedge clock);
      if_req_valid = 0;
      chk("t5 if arvalid", m_arvalid, 1);
      chk("t5 if araddr", m_araddr, 32'h200);
      chk("t5 if arprot", m_arprot, 3'b100);
      m_arready = 1; m_rvalid = 1; m_rdata = 32'h00000013; m_rresp = 2'b10;
      @(negedge clock);
      m_arready = 0; m_rvalid = 0; m_rresp = 2'b00;
      chk("t5 if rsp", if_rsp_valid, 1);
      chk("t5 if err", if_rsp_err, 1);
      chk("t5 no ls rsp", ls_rsp_valid, 0);
      @(negedge clock);
      chk("t5 if rsp single", if_rsp_valid, 0);
      $display("arb t5 load then fetch(SLVERR) done");

      // 6: reset while waiting for B, then a normal load
      ls_req_valid = 1; ls_we = 1; ls_size = 2'b10; ls_addr = 32'h108; ls_wdata = 32'hA5A5A5A5;
      #1;
      chk("t6 ls_req_ready", ls_req_ready, 1);
      @(negedge clock);
      ls_req_valid = 0; ls_we = 0;
      chk("t6 wstrb", m_wstrb, 4'b1111);
      m_awready = 1; m_wready = 1;
      @(negedge clock);
      m_awready = 0; m_wready = 0;
      chk("t6 in WR_B bready", m_bready, 1);
      chk("t6 in WR_B awvalid", m_awvalid, 0);
      r0 = ls_rsp_seen;
      resetn = 0;
      @(negedge clock);
      chk("t6 rst awvalid", m_awvalid, 0);
      chk("t6 rst wvalid", m_wvalid, 0);
      chk("t6 rst bready", m_bready, 0);
      chk("t6 rst arvalid", m_arvalid, 0);
      chk("t6 rst rready", m_rready, 0);
      chk("t6 rst rsp", ls_rsp_valid, 0);
      resetn = 1;
      @(negedge clock);
      chk("t6 no rsp after rst", ls_rsp_valid, 0);
      chk("t6 rsp count", ls_rsp_seen, r0);
      $display("reset t6 mid-write recovered");
      do_load("t6 lw", 32'h10C, 2'b10, 1'b0, 32'h5A5A0001, 32'h5A5A0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
